peri_rd_pipe_mux: RTL and testbench
===================================

// Module: peri_rd_pipe_mux
// PURPOSE
//  Parametrised read-return mux between the AHB-side decoder and NSLAVE peripheral slaves.
//  Samples the one-hot peripheral select in the address phase and registers it.
//  In the data phase it returns that slave's read data and ready.
//  Zero or multi-hot selects get a two-cycle AHB-style ERROR response.
//  An optional watchdog converts a hung slave into an ERROR response.
// PARAMETERS
//  NSLAVE      8    number of slave channels (1..32)
//  DW          32   read-data width
//  TMO_CYCLES  256  data-phase wait limit, in cycles, before forced error (>=2; used only with macro)
// PORTS
//  HCLK        in   1            clock, all flops rising edge
//  HRESETn     in   1            reset, asynchronous, active-low
//  PERIVALID   in   1            address phase valid (transfer request)
//  PERISEL     in   NSLAVE       one-hot slave select, qualified by PERIVALID
//  PERIDATA    in   NSLAVE*DW    slave read data, slave i at bits [i*DW +: DW]
//  PERIREADYS  in   NSLAVE       per-slave ready, bit i = slave i
//  PERIDATAR   out  DW           muxed read data to the master
//  PERIREADY   out  1            transfer done / address phase accepted
//  PERIERR     out  1            error response
//  DPSEL       out  NSLAVE       registered data-phase select, one-hot; 0 when none
// BEHAVIOUR
//  - Reset: state=IDLE, DPSEL=0, watchdog count=0.
//    Outputs during reset: PERIREADY=1, PERIDATAR=0, PERIERR=0.
//  - States: IDLE, DATA, ERR1, ERR2. All outputs are combinational from state, DPSEL and slave inputs.
//  - Address phase is accepted on a rising edge where PERIREADY=1 and PERIVALID=1.
//    * PERISEL exactly one-hot: DPSEL<=PERISEL, next state=DATA.
//    * PERISEL zero or multi-hot: DPSEL<=0, next state=ERR1.
//    * PERIVALID=0: DPSEL<=0, next state=IDLE.
//  - IDLE: PERIREADY=1, PERIDATAR=0, PERIERR=0.
//  - DATA: PERIREADY=|(PERIREADYS & DPSEL); PERIDATAR=selected slice; PERIERR=0.
//    * Ready=1 completes the transfer. The same edge evaluates the next address phase.
//    * Back-to-back transfers therefore have no idle cycle; 1-cycle latency per zero-wait slave.
//    * Ready=0 holds DATA, DPSEL and PERIDATAR source stable. PERISEL/PERIVALID are ignored.
//  - ERR1: PERIREADY=0, PERIERR=1, PERIDATAR=0; next state always ERR2. Inputs ignored.
//  - ERR2: PERIREADY=1, PERIERR=1, PERIDATAR=0.
//    * Counts as a ready cycle: the address-phase rules above apply (a new request is accepted).
//  - PERIDATAR is 0 whenever DPSEL=0. Unselected slave data never leaks (AND-OR mux, no priority).
//  - Slave index i maps to PERISEL bit i. Slave 0 is valid; there is no reserved slot.
//  - Async reset mid-transfer: immediate return to IDLE. The in-flight transfer is dropped, no error is flagged.
// CONFIGURATION
//  PERI_RD_PIPE_MUX_TIMEOUT_EN defined:
//    * The watchdog counter is cleared on entry to DATA.
//    * It increments each DATA cycle with selected ready=0.
//    * At count==TMO_CYCLES-1 with ready still 0, next state=ERR1 and DPSEL<=0. The slave response is abandoned.
//    * Ready=1 on that same cycle wins: normal completion, no error.
//  Macro undefined: no counter logic; DATA waits indefinitely for the slave.
// TESTING
//  1 Reset: HRESETn=0 -> PERIREADY=1, PERIERR=0, PERIDATAR=0, DPSEL=0; release -> IDLE.
//  2 Zero-wait read: PERIVALID=1, PERISEL=8'h04, PERIREADYS=8'hFF, slice2=32'hA5A5_0002
//    -> next cycle PERIDATAR=32'hA5A5_0002, PERIREADY=1.
//  3 Back-to-back: sel 8'h01 then 8'h80, no waits -> consecutive PERIREADY cycles return slice0 then slice7.
//  4 Wait states: sel 8'h10, PERIREADYS[4]=0 for 3 cycles -> PERIREADY=0 x3, DPSEL=8'h10 held.
//    PERISEL changed meanwhile is ignored; completes on the 4th cycle.
//  5 Illegal select: PERISEL=8'h06 (also 8'h00), PERIVALID=1 -> ERR1 (READY=0, ERR=1), ERR2 (READY=1, ERR=1).
//    A valid request in ERR2 is accepted.
//  6 Timeout (macro on, TMO_CYCLES=4): sel 8'h02, PERIREADYS[1] held 0
//    -> READY=0 for 4 DATA cycles, then ERR1, ERR2. Repeat with ready rising on cycle 4 -> normal completion, no error.

Source files
------------

// File: rtl/peri_rd_pipe_mux_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | peri_rd_pipe_mux_if : decoder/slave read-return bus bundle          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface peri_rd_pipe_mux_if #(
    parameter int NSLAVE = 8,
    parameter int DW     = 32
);
    logic                 PERIVALID;
    logic [NSLAVE-1:0]    PERISEL;
    logic [NSLAVE*DW-1:0] PERIDATA;
    logic [NSLAVE-1:0]    PERIREADYS;
    logic [DW-1:0]        PERIDATAR;
    logic                 PERIREADY;
    logic                 PERIERR;
    logic [NSLAVE-1:0]    DPSEL;

    modport master (
        output PERIVALID, PERISEL, PERIDATA, PERIREADYS,
        input  PERIDATAR, PERIREADY, PERIERR, DPSEL
    );

    modport slave (
        input  PERIVALID, PERISEL, PERIDATA, PERIREADYS,
        output PERIDATAR, PERIREADY, PERIERR, DPSEL
    );
endinterface
`default_nettype wire

// File: rtl/peri_rd_pipe_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | peri_rd_pipe_mux : pipelined read-return mux over NSLAVE slaves     |
// | Optional watchdog: PERI_RD_PIPE_MUX_TIMEOUT_EN                      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module peri_rd_pipe_mux #(
    parameter int NSLAVE     = 8,
    parameter int DW         = 32,
    parameter int TMO_CYCLES = 256
) (
    input  wire logic          HCLK,
    input  wire logic          HRESETn,
    peri_rd_pipe_mux_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [NSLAVE-1:0] r_dpsel;
    logic [NSLAVE-1:0] w_dpsel_nxt;
    logic [DW-1:0]     w_mux;
    logic              w_sel_ready;
    logic              w_onehot;
    logic              w_addr_ok;
    logic              w_timeout;
    logic              w_ready;
    logic              w_err;
    logic [DW-1:0]     w_datar;

    assign w_sel_ready = |(bus.PERIREADYS & r_dpsel);
    assign w_onehot    = (bus.PERISEL != '0) &&
                         ((bus.PERISEL & (bus.PERISEL - NSLAVE'(1))) == '0);
    assign w_addr_ok   = (r_state == S_IDLE) || (r_state == S_ERR2) ||
                         ((r_state == S_DATA) && w_sel_ready);

    // AND-OR mux: DPSEL is one-hot or zero, so no slice can leak through
    always_comb begin
        w_mux = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            w_mux = w_mux | (bus.PERIDATA[i*DW +: DW] & {DW{r_dpsel[i]}});
        end
    end

`ifdef PERI_RD_PIPE_MUX_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYCLES);

    logic [CW-1:0] r_wdog;

    assign w_timeout = (r_state == S_DATA) && !w_sel_ready &&
                       (r_wdog == CW'(TMO_CYCLES - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wdog <= '0;
        end else if ((r_state == S_DATA) && !w_sel_ready) begin
            r_wdog <= r_wdog + CW'(1);
        end else if (w_state_nxt == S_DATA) begin
            r_wdog <= '0;
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TMO_CYCLES < 2);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_dpsel <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dpsel <= w_dpsel_nxt;
        end
    end

    // Every ready cycle (IDLE, ERR2, completing DATA) doubles as an address phase
    always_comb begin
        w_state_nxt = r_state;
        w_dpsel_nxt = r_dpsel;
        if (w_timeout) begin
            w_state_nxt = S_ERR1;
            w_dpsel_nxt = '0;
        end else if (w_addr_ok) begin
            if (!bus.PERIVALID) begin
                w_state_nxt = S_IDLE;
                w_dpsel_nxt = '0;
            end else if (w_onehot) begin
                w_state_nxt = S_DATA;
                w_dpsel_nxt = bus.PERISEL;
            end else begin
                w_state_nxt = S_ERR1;
                w_dpsel_nxt = '0;
            end
        end else if (r_state == S_ERR1) begin
            w_state_nxt = S_ERR2;
        end
    end

    always_comb begin
        w_ready = 1'b1;
        w_err   = 1'b0;
        w_datar = '0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
            end
            S_DATA: begin
                w_ready = w_sel_ready;
                w_datar = w_mux;
            end
            S_ERR1: begin
                w_ready = 1'b0;
                w_err   = 1'b1;
            end
            S_ERR2: begin
                w_ready = 1'b1;
                w_err   = 1'b1;
            end
            default: begin
                w_ready = 1'b1;
            end
        endcase
    end

    assign bus.PERIREADY = w_ready;
    assign bus.PERIERR   = w_err;
    assign bus.PERIDATAR = w_datar;
    assign bus.DPSEL     = r_dpsel;

endmodule
`default_nettype wire

// File: tb/tb_peri_rd_pipe_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_peri_rd_pipe_mux : directed self-checking bench                  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_peri_rd_pipe_mux;

    logic HCLK;
    logic HRESETn;
    int   checks;
    int   errors;

    peri_rd_pipe_mux_if #(.NSLAVE(8), .DW(32)) bus ();

    peri_rd_pipe_mux #(
        .NSLAVE     (8),
        .DW         (32),
        .TMO_CYCLES (4)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rdy, input logic err,
                           input logic [31:0] datar, input logic [7:0] dpsel);
        chk({tag, "_ready"}, {31'b0, bus.PERIREADY}, {31'b0, rdy});
        chk({tag, "_err"},   {31'b0, bus.PERIERR},   {31'b0, err});
        chk({tag, "_datar"}, bus.PERIDATAR,          datar);
        chk({tag, "_dpsel"}, {24'b0, bus.DPSEL},     {24'b0, dpsel});
    endtask

    // Drive inputs after the falling edge, then let combinational outputs settle
    task automatic cyc(input logic v, input logic [7:0] s, input logic [7:0] r);
        @(negedge HCLK);
        bus.PERIVALID  = v;
        bus.PERISEL    = s;
        bus.PERIREADYS = r;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        HRESETn        = 1'b0;
        bus.PERIVALID  = 1'b0;
        bus.PERISEL    = 8'h00;
        bus.PERIREADYS = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            bus.PERIDATA[i*32 +: 32] = 32'hA5A5_0000 | i;
        end

        // Reset, including a request presented while held in reset
        #1;
        chk_out("rst0", 1'b1, 1'b0, 32'h0, 8'h00);
        cyc(1'b1, 8'h04, 8'hFF);
        cyc(1'b1, 8'h04, 8'hFF);
        chk_out("rst1", 1'b1, 1'b0, 32'h0, 8'h00);
        @(negedge HCLK);
        HRESETn = 1'b1;
        bus.PERIVALID = 1'b0;

        // Zero-wait read from slave 2
        cyc(1'b1, 8'h04, 8'hFF);
        chk_out("zw_addr", 1'b1, 1'b0, 32'h0, 8'h00);
        cyc(1'b0, 8'h00, 8'hFF);
        chk_out("zw_data", 1'b1, 1'b0, 32'hA5A5_0002, 8'h04);
        cyc(1'b0, 8'h00, 8'hFF);
        chk_out("zw_idle", 1'b1, 1'b0, 32'h0, 8'h00);

        // Back-to-back slave 0 then slave 7
        cyc(1'b1, 8'h01, 8'hFF);
        cyc(1'b1, 8'h80, 8'hFF);
        chk_out("b2b_s0", 1'b1, 1'b0, 32'hA5A5_0000, 8'h01);
        cyc(1'b0, 8'h00, 8'hFF);
        chk_out("b2b_s7", 1'b1, 1'b0, 32'hA5A5_0007, 8'h80);

        // Three wait states on slave 4, with PERISEL changing underneath
        cyc(1'b1, 8'h10, 8'hEF);
        cyc(1'b1, 8'h03, 8'hEF);
        chk_out("ws1", 1'b0, 1'b0, 32'hA5A5_0004, 8'h10);
        cyc(1'b1, 8'h20, 8'hEF);
        chk_out("ws2", 1'b0, 1'b0, 32'hA5A5_0004, 8'h10);
        cyc(1'b1, 8'h40, 8'hEF);
        chk_out("ws3", 1'b0, 1'b0, 32'hA5A5_0004, 8'h10);
        cyc(1'b0, 8'h00, 8'hFF);
        chk_out("ws_done", 1'b1, 1'b0, 32'hA5A5_0004, 8'h10);
        cyc(1'b0, 8'h00, 8'hFF);
        chk_out("ws_idle", 1'b1, 1'b0, 32'h0, 8'h00);

        // Multi-hot, then zero-hot from ERR2, then a legal request from ERR2
        cyc(1'b1, 8'h06, 8'hFF);
        cyc(1'b0, 8'h00, 8'hFF);
        chk_out("mh_err1", 1'b0, 1'b1, 32'h0, 8'h00);
        cyc(1'b1, 8'h00, 8'hFF);
        chk_out("mh_err2", 1'b1, 1'b1, 32'h0, 8'h00);
        cyc(1'b1, 8'h08, 8'hFF);
        chk_out("zh_err1", 1'b0, 1'b1, 32'h0, 8'h00);
        cyc(1'b1, 8'h08, 8'hFF);
        chk_out("zh_err2", 1'b1, 1'b1, 32'h0, 8'h00);
        cyc(1'b0, 8'h00, 8'hFF);
        chk_out("err2_acc", 1'b1, 1'b0, 32'hA5A5_0003, 8'h08);

`ifdef PERI_RD_PIPE_MUX_TIMEOUT_EN
        // Hung slave 1: four waiting DATA cycles, then forced error
        cyc(1'b1, 8'h02, 8'hFD);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 8'hFD);
            chk_out($sformatf("tmo_wait%0d", i), 1'b0, 1'b0, 32'hA5A5_0001, 8'h02);
        end
        cyc(1'b0, 8'h00, 8'hFD);
        chk_out("tmo_err1", 1'b0, 1'b1, 32'h0, 8'h00);
        cyc(1'b0, 8'h00, 8'hFD);
        chk_out("tmo_err2", 1'b1, 1'b1, 32'h0, 8'h00);
        cyc(1'b0, 8'h00, 8'hFD);
        chk_out("tmo_idle", 1'b1, 1'b0, 32'h0, 8'h00);

        // Ready arrives on the last permitted cycle: normal completion
        cyc(1'b1, 8'h02, 8'hFD);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 8'hFD);
            chk_out($sformatf("late_wait%0d", i), 1'b0, 1'b0, 32'hA5A5_0001, 8'h02);
        end
        cyc(1'b0, 8'h00, 8'hFF);
        chk_out("late_done", 1'b1, 1'b0, 32'hA5A5_0001, 8'h02);
        cyc(1'b0, 8'h00, 8'hFF);
        chk_out("late_idle", 1'b1, 1'b0, 32'h0, 8'h00);
`else
        // Without the watchdog a hung slave is waited on indefinitely
        cyc(1'b1, 8'h02, 8'hFD);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'h00, 8'hFD);
            chk_out($sformatf("hang%0d", i), 1'b0, 1'b0, 32'hA5A5_0001, 8'h02);
        end
        cyc(1'b0, 8'h00, 8'hFF);
        chk_out("hang_done", 1'b1, 1'b0, 32'hA5A5_0001, 8'h02);
        cyc(1'b0, 8'h00, 8'hFF);
        chk_out("hang_idle", 1'b1, 1'b0, 32'h0, 8'h00);
`endif

        // Asynchronous reset in the middle of a waiting transfer
        cyc(1'b1, 8'h10, 8'hEF);
        cyc(1'b0, 8'h00, 8'hEF);
        chk_out("ar_busy", 1'b0, 1'b0, 32'hA5A5_0004, 8'h10);
        #1;
        HRESETn = 1'b0;
        #1;
        chk_out("ar_rst", 1'b1, 1'b0, 32'h0, 8'h00);
        @(negedge HCLK);
        HRESETn = 1'b1;
        cyc(1'b0, 8'h00, 8'hFF);
        chk_out("ar_idle", 1'b1, 1'b0, 32'h0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
